// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type, stall counter width and one-hot decode helper for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int STALL_W = 16;
  function automatic int unsigned oh2idx(input logic [31:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) if (oh[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, searching upward (modulo N) from ptr+1
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  oh,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  // Walk from the farthest candidate back to ptr+1 so the nearest valid one wins
  always_comb begin
    oh = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) oh = N'(1) << j;
    end
  end
  assign idx = IW'(oh2idx(32'(oh)));
  assign any = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: burst-based round-robin sharing of the FIFO write port with a saturating stall counter
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_BURST  = 4,
  parameter int BCNT_WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]       req_last_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     wr_en_o,
  output logic [WIDTH-1:0]         wdata_o,
  input  logic                     full_i,
  output logic                     busy_o,
  output logic [STALL_W-1:0]       stall_cnt_o
);
  localparam int IW = $clog2(NUM_REQ);
  state_t                state_q, state_n;
  logic [NUM_REQ-1:0]    grant_q, pick_oh;
  logic [IW-1:0]         ptr_q, pick_idx;
  logic [BCNT_WIDTH-1:0] bcnt_q;
  logic [STALL_W-1:0]    stall_q;
  logic [WIDTH-1:0]      wdata_q, cur_data;
  logic                  pick_any, burst_end, cur_valid;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req_valid_i), .ptr(ptr_q), .oh(pick_oh), .idx(pick_idx), .any(pick_any)
  );
  // While bursting the pointer always equals the granted index
  assign busy_o      = state_q == BURST;
  assign cur_valid   = req_valid_i[ptr_q];
  assign cur_data    = req_data_i[int'(ptr_q)*WIDTH +: WIDTH];
  assign wr_en_o     = busy_o & cur_valid & ~full_i;
  assign req_ready_o = full_i ? '0 : grant_q;
  assign grant_o     = grant_q;
  assign wdata_o     = wr_en_o ? cur_data : wdata_q;
  assign stall_cnt_o = stall_q;
  assign burst_end   = busy_o & (~cur_valid | (wr_en_o & (req_last_i[ptr_q] | bcnt_q == BCNT_WIDTH'(MAX_BURST-1))));
  always_comb begin
    state_n = (!busy_o || burst_end) ? (pick_any ? BURST : IDLE) : state_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(NUM_REQ-1);
      bcnt_q  <= '0;
      stall_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_n;
      if (!busy_o || burst_end) begin
        grant_q <= pick_oh;
        bcnt_q  <= '0;
        if (pick_any) ptr_q <= pick_idx;
      end else if (wr_en_o) bcnt_q <= bcnt_q + 1'b1;
      if (wr_en_o) wdata_q <= cur_data;
      if (busy_o && full_i && cur_valid && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
  end
endmodule
